// File: rtl/sh_ext_bus_ctrl_if.sv
// SH7604 external-bus pins plus the downstream memory port of sh_ext_bus_ctrl.
// Memory handshake: mem_req holds high with stable mem_a/mem_d/mem_be/mem_wr until a one-cycle mem_ack.
interface sh_ext_bus_ctrl_if;
    logic        ce_r;
    logic [26:0] a;
    logic [31:0] wdata;     // CPU DO pins ("do" is a reserved word)
    logic        bs_n;
    logic        cs0_n;
    logic        cs3_n;
    logic        rd_wr_n;
    logic [3:0]  we_n;
    logic [1:0]  cs0_sz;
    logic [31:0] di;
    logic        wait_n;
    logic [26:0] mem_a;
    logic [31:0] mem_d;
    logic [3:0]  mem_be;
    logic        mem_wr;
    logic        mem_req;
    logic [31:0] mem_q;
    logic        mem_ack;
    logic        err;

    modport slave (
        input  ce_r, a, wdata, bs_n, cs0_n, cs3_n, rd_wr_n, we_n, cs0_sz, mem_q, mem_ack,
        output di, wait_n, mem_a, mem_d, mem_be, mem_wr, mem_req, err
    );

    modport master (
        output ce_r, a, wdata, bs_n, cs0_n, cs3_n, rd_wr_n, we_n, cs0_sz, mem_q, mem_ack,
        input  di, wait_n, mem_a, mem_d, mem_be, mem_wr, mem_req, err
    );
endinterface

// File: rtl/sh_ext_bus_ctrl.sv
// SH7604 external-bus slave: CS0/CS3 decode, WAIT_N wait states, one req/ack memory access.
// Optional MEM-state timeout with ERR pulse is enabled by defining SH_BUS_TIMEOUT_EN.
module sh_ext_bus_ctrl #(
    parameter int CS0_WAITS = 2,
    parameter int CS3_WAITS = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               rst,
    sh_ext_bus_ctrl_if.slave   bus,
    output logic [1:0]         dbg_state
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic        is_read;
    logic        is16;
    logic        start;
    logic        sel16;
    logic        timeout;
    logic [15:0] half;

    assign start     = bus.ce_r && !bus.bs_n && (!bus.cs0_n || !bus.cs3_n);
    assign sel16     = !bus.cs0_n && (bus.cs0_sz == 2'b01);
    assign half      = bus.mem_a[1] ? bus.mem_q[15:0] : bus.mem_q[31:16];
    assign dbg_state = state;

`ifdef SH_BUS_TIMEOUT_EN
    logic [7:0] to_cnt;

    assign timeout = bus.ce_r && (to_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= 8'd0;
            bus.err <= 1'b0;
        end else begin
            bus.err <= (state == ST_MEM) && !bus.mem_ack && timeout;
            if (state != ST_MEM)
                to_cnt <= 8'd0;
            else if (bus.ce_r)
                to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
    assign bus.err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= 8'd0;
            is_read     <= 1'b0;
            is16        <= 1'b0;
            bus.di      <= 32'd0;
            bus.wait_n  <= 1'b1;
            bus.mem_a   <= 27'd0;
            bus.mem_d   <= 32'd0;
            bus.mem_be  <= 4'd0;
            bus.mem_wr  <= 1'b0;
            bus.mem_req <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus.mem_a  <= bus.a;
                        bus.mem_d  <= bus.wdata;
                        bus.mem_wr <= !bus.rd_wr_n;
                        is_read    <= bus.rd_wr_n;
                        is16       <= sel16;
                        if (!bus.rd_wr_n)
                            bus.mem_be <= ~bus.we_n;
                        else if (sel16)
                            bus.mem_be <= bus.a[1] ? 4'h3 : 4'hC;
                        else
                            bus.mem_be <= 4'hF;
                        // CS0 wins when both selects are asserted
                        wait_cnt   <= !bus.cs0_n ? 8'(CS0_WAITS) : 8'(CS3_WAITS);
                        bus.wait_n <= 1'b0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.ce_r) begin
                        if (wait_cnt <= 8'd1) begin
                            bus.mem_req <= 1'b1;
                            state       <= ST_MEM;
                        end else begin
                            wait_cnt <= wait_cnt - 8'd1;
                        end
                    end
                end
                ST_MEM: begin
                    // mem_ack is honoured on any clk, independent of ce_r
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.wait_n  <= 1'b1;
                        state       <= ST_DONE;
                        if (is_read)
                            bus.di <= is16 ? {half, half} : bus.mem_q;
                    end else if (timeout) begin
                        bus.mem_req <= 1'b0;
                        bus.wait_n  <= 1'b1;
                        state       <= ST_DONE;
                        if (is_read)
                            bus.di <= 32'hFFFF_FFFF;
                    end
                end
                ST_DONE: begin
                    if (bus.ce_r)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
